// File: rtl/pkt_pkg.sv
// Shared constants and types for the packet-granular port arbiter.
package pkt_pkg;

  localparam int unsigned DATA_W = 134;

  typedef enum logic [1:0] {
    PKT_HEAD = 2'b01,
    PKT_MID  = 2'b11,
    PKT_TAIL = 2'b10
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_SEND
  } arb_state_e;

  function automatic logic is_tail(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: 2] == PKT_TAIL;
  endfunction

endpackage

// File: rtl/port_in_buf.sv
// Per-input buffer: word data FIFO, per-packet valid FIFO, complete-packet
// count, almost-full and sticky overflow flags.
module port_in_buf
  import pkt_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 8,
  parameter int unsigned PKT_AW     = 4,
  parameter int unsigned ALF_MARGIN = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              valid,
  input  logic              valid_wr,
  input  logic              rd_en,
  input  logic              vld_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              vld_head,
  output logic [PKT_AW:0]   pkt_cnt,
  output logic              alf,
  output logic              ovf
);

  localparam int unsigned     DEPTH     = 2**FIFO_AW;
  localparam int unsigned     PKT_DEPTH = 2**PKT_AW;
  localparam logic [FIFO_AW:0]  PTR_ONE  = 1;
  localparam logic [PKT_AW-1:0] VPTR_ONE = 1;
  localparam logic [PKT_AW:0]   CNT_ONE  = 1;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic              vmem [PKT_DEPTH];

  logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, data_cnt;
  logic [PKT_AW-1:0] vwr_ptr_q, vwr_ptr_d, vrd_ptr_q, vrd_ptr_d;
  logic [PKT_AW:0]   pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ovf_q, ovf_d;
  logic              data_full, data_empty, vld_full;
  logic              data_push, data_pop, vld_push, vld_pop_ok;
  int unsigned       free_words, free_slots;

  always_comb begin
    // Occupancy never exceeds DEPTH, so its MSB alone marks full.
    data_cnt   = wr_ptr_q - rd_ptr_q;
    data_full  = data_cnt[FIFO_AW];
    data_empty = (data_cnt == '0);
    vld_full   = pkt_cnt_q[PKT_AW];
    data_push  = wr_en && !data_full;
    data_pop   = rd_en && !data_empty;
    vld_push   = valid_wr && !vld_full;
    vld_pop_ok = vld_pop && (pkt_cnt_q != '0);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    vwr_ptr_d = vwr_ptr_q;
    vrd_ptr_d = vrd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    rd_data_d = rd_data_q;

    if (data_push)  wr_ptr_d  = wr_ptr_q + PTR_ONE;
    if (vld_push)   vwr_ptr_d = vwr_ptr_q + VPTR_ONE;
    if (vld_pop_ok) vrd_ptr_d = vrd_ptr_q + VPTR_ONE;
    if (data_pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      rd_data_d = mem[rd_ptr_q[FIFO_AW-1:0]];
    end

    if (vld_push && !vld_pop_ok)      pkt_cnt_d = pkt_cnt_q + CNT_ONE;
    else if (!vld_push && vld_pop_ok) pkt_cnt_d = pkt_cnt_q - CNT_ONE;

    ovf_d = ovf_q || (wr_en && data_full) || (valid_wr && vld_full);

    free_words = DEPTH - 32'(data_cnt);
    free_slots = PKT_DEPTH - 32'(pkt_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      vwr_ptr_q <= '0;
      vrd_ptr_q <= '0;
      pkt_cnt_q <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vwr_ptr_q <= vwr_ptr_d;
      vrd_ptr_q <= vrd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_push) mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
    if (vld_push)  vmem[vwr_ptr_q] <= valid;
  end

  assign rd_data  = rd_data_q;
  assign vld_head = vmem[vrd_ptr_q];
  assign pkt_cnt  = pkt_cnt_q;
  assign alf      = (free_words <= ALF_MARGIN) || (free_slots <= 32'd1);
  assign ovf      = ovf_q;

endmodule

// File: rtl/port_pkt_arb.sv
// 2:1 packet-granular arbiter merging direct-forward and TSN/normal streams.
// Define ARB_STRICT_PRI_EN for strict input-0 priority instead of round-robin.
module port_pkt_arb
  import pkt_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 8,
  parameter int unsigned PKT_AW     = 4,
  parameter int unsigned ALF_MARGIN = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic              in_data_wr0,
  input  logic              in_data_wr1,
  input  logic              in_valid0,
  input  logic              in_valid1,
  input  logic              in_valid_wr0,
  input  logic              in_valid_wr1,
  output logic              in_alf0,
  output logic              in_alf1,
  input  logic              out_alf,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  output logic [63:0]       out_pkt_cnt,
  output logic [1:0]        ovf_err
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
`ifndef ARB_STRICT_PRI_EN
  logic              rr_ptr_q, rr_ptr_d;
`endif
  logic [DATA_W-1:0] out_data_q, out_data_d, send_word;
  logic              out_data_wr_q, out_data_wr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_valid_wr_q, out_valid_wr_d;
  logic [63:0]       out_pkt_cnt_q, out_pkt_cnt_d;

  logic [DATA_W-1:0] rd_data [2];
  logic [PKT_AW:0]   pkt_cnt [2];
  logic [1:0]        rd_en, vld_pop, vld_head, alf, ovf;

  port_in_buf #(.FIFO_AW(FIFO_AW), .PKT_AW(PKT_AW), .ALF_MARGIN(ALF_MARGIN)) u_buf0 (
    .clk(clk), .rst_n(rst_n), .wr_data(in_data0), .wr_en(in_data_wr0),
    .valid(in_valid0), .valid_wr(in_valid_wr0), .rd_en(rd_en[0]), .vld_pop(vld_pop[0]),
    .rd_data(rd_data[0]), .vld_head(vld_head[0]), .pkt_cnt(pkt_cnt[0]),
    .alf(alf[0]), .ovf(ovf[0])
  );

  port_in_buf #(.FIFO_AW(FIFO_AW), .PKT_AW(PKT_AW), .ALF_MARGIN(ALF_MARGIN)) u_buf1 (
    .clk(clk), .rst_n(rst_n), .wr_data(in_data1), .wr_en(in_data_wr1),
    .valid(in_valid1), .valid_wr(in_valid_wr1), .rd_en(rd_en[1]), .vld_pop(vld_pop[1]),
    .rd_data(rd_data[1]), .vld_head(vld_head[1]), .pkt_cnt(pkt_cnt[1]),
    .alf(alf[1]), .ovf(ovf[1])
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
`ifndef ARB_STRICT_PRI_EN
    rr_ptr_d       = rr_ptr_q;
`endif
    rd_en          = '0;
    vld_pop        = '0;
    out_data_d     = '0;
    out_data_wr_d  = 1'b0;
    out_valid_d    = 1'b0;
    out_valid_wr_d = 1'b0;
    send_word      = rd_data[grant_q];

    unique case (state_q)
      ST_IDLE: begin
        if (((pkt_cnt[0] != '0) || (pkt_cnt[1] != '0)) && !out_alf) state_d = ST_ARB;
      end
      ST_ARB: begin
`ifdef ARB_STRICT_PRI_EN
        grant_d  = (pkt_cnt[0] != '0) ? 1'b0 : 1'b1;
`else
        grant_d  = (pkt_cnt[rr_ptr_q] != '0) ? rr_ptr_q : ~rr_ptr_q;
        rr_ptr_d = ~grant_d;
`endif
        rd_en[grant_d] = 1'b1;
        state_d        = ST_SEND;
      end
      ST_SEND: begin
        // Read-ahead stops at the tail so the next packet's head stays queued.
        out_data_d    = send_word;
        out_data_wr_d = 1'b1;
        if (is_tail(send_word)) begin
          vld_pop[grant_q] = 1'b1;
          out_valid_d      = vld_head[grant_q];
          out_valid_wr_d   = 1'b1;
          state_d          = ST_IDLE;
        end else begin
          rd_en[grant_q] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_pkt_cnt_d = out_pkt_cnt_q + 64'(out_valid_wr_q && out_valid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b0;
`ifndef ARB_STRICT_PRI_EN
      rr_ptr_q       <= 1'b0;
`endif
      out_data_q     <= '0;
      out_data_wr_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
      out_pkt_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
`ifndef ARB_STRICT_PRI_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
      out_data_q     <= out_data_d;
      out_data_wr_q  <= out_data_wr_d;
      out_valid_q    <= out_valid_d;
      out_valid_wr_q <= out_valid_wr_d;
      out_pkt_cnt_q  <= out_pkt_cnt_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_data_wr  = out_data_wr_q;
  assign out_valid    = out_valid_q;
  assign out_valid_wr = out_valid_wr_q;
  assign out_pkt_cnt  = out_pkt_cnt_q;
  assign in_alf0      = alf[0];
  assign in_alf1      = alf[1];
  assign ovf_err      = ovf;

endmodule

// File: tb/tb_port_pkt_arb.sv
// Directed self-checking bench for port_pkt_arb; honours ARB_STRICT_PRI_EN.
module tb_port_pkt_arb;
  import pkt_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data0 = '0, in_data1 = '0;
  logic              in_data_wr0 = 1'b0, in_data_wr1 = 1'b0;
  logic              in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic              in_valid_wr0 = 1'b0, in_valid_wr1 = 1'b0;
  logic              in_alf0, in_alf1;
  logic              out_alf = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_data_wr, out_valid, out_valid_wr;
  logic [63:0]       out_pkt_cnt;
  logic [1:0]        ovf_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  logic [DATA_W-1:0] q_word [$];
  int unsigned       q_cyc  [$];
  logic              q_vld  [$];
  int unsigned       vld_cyc[$];

  port_pkt_arb dut (
    .clk(clk), .rst_n(rst_n),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_data_wr0(in_data_wr0), .in_data_wr1(in_data_wr1),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_valid_wr0(in_valid_wr0), .in_valid_wr1(in_valid_wr1),
    .in_alf0(in_alf0), .in_alf1(in_alf1),
    .out_alf(out_alf),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_valid(out_valid), .out_valid_wr(out_valid_wr),
    .out_pkt_cnt(out_pkt_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_word(input int unsigned src, input int unsigned pkt,
                                                input int unsigned w, input int unsigned nw);
    logic [19:0] b;
    logic [1:0]  t;
    b = {4'(src), 8'(pkt), 8'(w)};
    t = (w == nw - 1) ? 2'b10 : ((w == 0) ? 2'b01 : 2'b11);
    return {t, b, ~b, b, ~b, b, ~b, b[11:0]};
  endfunction

  always @(negedge clk) begin
    if (out_data_wr) begin
      q_word.push_back(out_data);
      q_cyc.push_back(cyc);
    end
    if (out_valid_wr) begin
      q_vld.push_back(out_valid);
      vld_cyc.push_back(cyc);
      check("vwr_on_tail", 134'({out_data_wr, out_data[133:132]}), 134'(3'b110));
    end
  end

  task automatic clear_q();
    q_word.delete(); q_cyc.delete(); q_vld.delete(); vld_cyc.delete();
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_q();
  endtask

  task automatic put_pkt(input logic [1:0] mask, input int unsigned pkt, input int unsigned nw,
                         input logic v0, input logic v1);
    for (int unsigned w = 0; w < nw; w++) begin
      in_data0     = mk_word(0, pkt, w, nw);
      in_data1     = mk_word(1, pkt, w, nw);
      in_data_wr0  = mask[0];
      in_data_wr1  = mask[1];
      in_valid0    = v0;
      in_valid1    = v1;
      in_valid_wr0 = mask[0] && (w == nw - 1);
      in_valid_wr1 = mask[1] && (w == nw - 1);
      step(1);
    end
    in_data_wr0 = 1'b0; in_data_wr1 = 1'b0;
    in_valid_wr0 = 1'b0; in_valid_wr1 = 1'b0;
  endtask

  task automatic put_words1(input int unsigned n);
    in_data1 = mk_word(1, 0, 1, 3);
    in_data_wr1 = 1'b1;
    step(n);
    in_data_wr1 = 1'b0;
  endtask

  task automatic wait_words(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (q_word.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 134'(q_word.size()), 134'(n));
  endtask

  task automatic wait_vld(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (q_vld.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 134'(q_vld.size()), 134'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t, src, pkt;
    step(3);
    check("rst_data_wr", 134'(out_data_wr), 134'(0));
    check("rst_valid_wr", 134'({out_valid, out_valid_wr}), 134'(0));
    check("rst_data", out_data, '0);
    check("rst_pkt_cnt", 134'(out_pkt_cnt), 134'(0));
    check("rst_flags", 134'({in_alf1, in_alf0, ovf_err}), 134'(0));
    rst_n = 1'b1;
    step(1);
    clear_q();

    // single 4-word packet on input 0
    put_pkt(2'b01, 0, 4, 1'b1, 1'b0);
    t = cyc;
    wait_vld(1, 30, "t1_vld_seen");
    step(2);
    check("t1_words", 134'(q_word.size()), 134'(4));
    for (int unsigned w = 0; w < 4; w++) check("t1_word", q_word[w], mk_word(0, 0, w, 4));
    check("t1_first_beat", 134'(q_cyc[0]), 134'(t + 3));
    check("t1_last_beat", 134'(q_cyc[3]), 134'(t + 6));
    check("t1_vwr_cyc", 134'(vld_cyc[0]), 134'(t + 6));
    check("t1_valid", 134'(q_vld[0]), 134'(1));
    check("t1_pkt_cnt", 134'(out_pkt_cnt), 134'(1));

    // simultaneous 3-word packets on both inputs, four times
    do_reset();
    for (int unsigned k = 0; k < 4; k++) put_pkt(2'b11, k, 3, 1'b1, 1'b1);
    wait_vld(8, 120, "t2_vld_seen");
    step(2);
    check("t2_words", 134'(q_word.size()), 134'(24));
    for (int unsigned p = 0; p < 8; p++) begin
`ifdef ARB_STRICT_PRI_EN
      src = (p < 4) ? 0 : 1;
      pkt = p % 4;
`else
      src = p % 2;
      pkt = p / 2;
`endif
      for (int unsigned w = 0; w < 3; w++) check("t2_order", q_word[p*3 + w], mk_word(src, pkt, w, 3));
    end
    check("t2_pkt_cnt", 134'(out_pkt_cnt), 134'(8));

    // discarded packet still forwarded, not counted
    clear_q();
    put_pkt(2'b10, 9, 3, 1'b0, 1'b0);
    wait_vld(1, 40, "t3_vld_seen");
    step(3);
    for (int unsigned w = 0; w < 3; w++) check("t3_word", q_word[w], mk_word(1, 9, w, 3));
    check("t3_valid", 134'(q_vld[0]), 134'(0));
    check("t3_pkt_cnt", 134'(out_pkt_cnt), 134'(8));

    // downstream backpressure before and during a packet
    clear_q();
    out_alf = 1'b1;
    put_pkt(2'b01, 5, 3, 1'b1, 1'b0);
    step(20);
    check("t4_held", 134'(q_word.size()), 134'(0));
    out_alf = 1'b0;
    wait_vld(1, 40, "t4_resume");
    check("t4_words", 134'(q_word.size()), 134'(3));
    check("t4_head", q_word[0], mk_word(0, 5, 0, 3));
    clear_q();
    put_pkt(2'b01, 6, 8, 1'b1, 1'b0);
    wait_words(1, 40, "t4_mid_start");
    out_alf = 1'b1;
    wait_vld(1, 40, "t4_mid_done");
    check("t4_mid_words", 134'(q_word.size()), 134'(8));
    check("t4_mid_tail", q_word[7], mk_word(0, 6, 7, 8));
    out_alf = 1'b0;
    step(3);
    check("t4_pkt_cnt", 134'(out_pkt_cnt), 134'(10));

    // fill input 1 past capacity with output blocked
    do_reset();
    out_alf = 1'b1;
    put_words1(127);
    check("t5_alf_127", 134'(in_alf1), 134'(0));
    put_words1(1);
    check("t5_alf_128", 134'({in_alf1, in_alf0}), 134'(2'b10));
    put_words1(128);
    check("t5_full_no_ovf", 134'(ovf_err), 134'(0));
    put_words1(4);
    check("t5_ovf", 134'(ovf_err), 134'(2'b10));
    // packet-slot almost-full on input 0
    for (int unsigned k = 0; k < 14; k++) put_pkt(2'b01, k, 2, 1'b1, 1'b0);
    check("t5_slot_14", 134'(in_alf0), 134'(0));
    put_pkt(2'b01, 14, 2, 1'b1, 1'b0);
    check("t5_slot_15", 134'(in_alf0), 134'(1));
    check("t5_no_out", 134'(q_word.size()), 134'(0));

    // reset in the middle of a packet
    do_reset();
    out_alf = 1'b0;
    put_pkt(2'b01, 7, 10, 1'b1, 1'b0);
    wait_words(2, 40, "t6_started");
    rst_n = 1'b0;
    #2;
    check("t6_rst_out", 134'({out_data_wr, out_valid, out_valid_wr}), 134'(0));
    check("t6_rst_data", out_data, '0);
    check("t6_rst_cnt", 134'({out_pkt_cnt, ovf_err}), 134'(0));
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_q();
    step(30);
    check("t6_quiet", 134'(q_word.size() + q_vld.size()), 134'(0));
    check("t6_alf", 134'({in_alf1, in_alf0}), 134'(0));
    put_pkt(2'b01, 8, 2, 1'b1, 1'b0);
    wait_vld(1, 30, "t6_after_vld");
    check("t6_after_words", 134'(q_word.size()), 134'(2));
    check("t6_after_head", q_word[0], mk_word(0, 8, 0, 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
